// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit for the 16-bit CPU.
// Each instruction is sequenced through FETCH, DECODE, EXEC, MEM and WB.
// The memory handshake can stall FETCH and MEM. A wait counter turns an
// access that never completes into a bus error. Undefined opcodes are
// flagged in DECODE.
module multicycle_control_unit #(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 2,
  parameter int MAX_WAIT = 15
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic                Zero,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                PCSrc,
  output logic                IRWrite,
  output logic                IorD,
  output logic                RegDst,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemToReg,
  output logic [1:0]          AluSrcB,
  output logic [ALUOP_W-1:0]  AluOp,
  output logic                RegWrite,
  output logic                Shift,
  output logic                InstrDone,
  output logic                Illegal,
  output logic                BusError,
  output logic [2:0]          State
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {C_R, C_SHIFT, C_I, C_LW, C_SW, C_BEQ, C_ILL} cls_t;

  localparam logic [7:0] MAXW = 8'(MAX_WAIT);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [OPCODE_W-1:0] op_q;
  cls_t                cls;

  logic       pcw, pcs, irw, iord, rd, mr, mw, m2r, rw, sh, dn, il, be;
  logic [1:0] asb, aop;

  // Any bit above the 4-bit opcode field makes the instruction undefined.
  function automatic cls_t classify(input logic [OPCODE_W-1:0] op);
    if (|(op >> 4)) return C_ILL;
    case (op[3:0])
      4'b0000, 4'b0001:          return C_R;
      4'b0010:                   return C_SHIFT;
      4'b1001, 4'b1010, 4'b1011: return C_I;
      4'b1100:                   return C_LW;
      4'b1101:                   return C_SW;
      4'b1111:                   return C_BEQ;
      default:                   return C_ILL;
    endcase
  endfunction

  // The live opcode only matters in DECODE; later states use the latched copy.
  assign cls = (state_q == S_DECODE) ? classify(OPCODE) : classify(op_q);

  // Next state and raw control decode.
  always_comb begin
    state_d = state_q;
    pcw = 1'b0; pcs = 1'b0; irw = 1'b0; iord = 1'b0; rd = 1'b0;
    mr  = 1'b0; mw  = 1'b0; m2r = 1'b0; rw   = 1'b0; sh = 1'b0;
    dn  = 1'b0; il  = 1'b0; be  = 1'b0;
    asb = 2'b00; aop = 2'b00;
    case (state_q)
      S_FETCH: begin
        mr  = 1'b1;
        asb = 2'b10;
        if (MemReady) begin
          irw     = 1'b1;
          pcw     = 1'b1;
          state_d = S_DECODE;
        end else if (cnt_q == MAXW) begin
          be = 1'b1;
          dn = 1'b1;
        end
      end
      S_DECODE: begin
        asb = 2'b11;
        if (cls == C_ILL) begin
          il      = 1'b1;
          dn      = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_R, C_SHIFT: begin asb = 2'b00; aop = 2'b10; state_d = S_WB;  end
          C_I:          begin asb = 2'b01; aop = 2'b11; state_d = S_WB;  end
          C_LW, C_SW:   begin asb = 2'b01; aop = 2'b00; state_d = S_MEM; end
          C_BEQ: begin
            asb = 2'b00; aop = 2'b01;
            pcs = 1'b1;  pcw = Zero;
            dn  = 1'b1;  state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        iord = 1'b1;
        mr   = (cls == C_LW);
        mw   = (cls == C_SW);
        if (MemReady) begin
          if (cls == C_LW) begin
            state_d = S_WB;
          end else begin
            dn      = 1'b1;
            state_d = S_FETCH;
          end
        end else if (cnt_q == MAXW) begin
          be      = 1'b1;
          dn      = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        rw      = 1'b1;
        dn      = 1'b1;
        rd      = (cls == C_R) || (cls == C_SHIFT);
        m2r     = (cls == C_LW);
        sh      = (cls == C_SHIFT);
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Count only genuine stall cycles. A state change or a timeout restarts the count.
  always_comb begin
    cnt_d = 8'd0;
    if ((state_q == S_FETCH || state_q == S_MEM) && !MemReady && !be &&
        state_d == state_q)
      cnt_d = cnt_q + 8'd1;
  end

  // State, wait counter and latched opcode.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 8'd0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_DECODE) op_q <= OPCODE;
    end
  end

  // Outputs are forced low for as long as Reset is held.
  assign PCWrite   = pcw  & ~Reset;
  assign PCSrc     = pcs  & ~Reset;
  assign IRWrite   = irw  & ~Reset;
  assign IorD      = iord & ~Reset;
  assign RegDst    = rd   & ~Reset;
  assign MemRead   = mr   & ~Reset;
  assign MemWrite  = mw   & ~Reset;
  assign MemToReg  = m2r  & ~Reset;
  assign RegWrite  = rw   & ~Reset;
  assign Shift     = sh   & ~Reset;
  assign InstrDone = dn   & ~Reset;
  assign Illegal   = il   & ~Reset;
  assign BusError  = be   & ~Reset;
  assign AluSrcB   = Reset ? 2'b00 : asb;
  assign AluOp     = Reset ? '0 : ALUOP_W'(aop);
  assign State     = Reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit.
// A per-instruction model expands an opcode and its memory wait pattern into
// the expected control vector for each cycle. The bench then plays that trace
// against the DUT.
module tb_multicycle_control_unit;

  localparam int MAX_WAIT = 15;

  logic       Clock, Reset;
  logic [3:0] OPCODE;
  logic       Zero, MemReady;
  logic       PCWrite, PCSrc, IRWrite, IorD, RegDst, MemRead, MemWrite, MemToReg;
  logic [1:0] AluSrcB, AluOp;
  logic       RegWrite, Shift, InstrDone, Illegal, BusError;
  logic [2:0] State;
  logic [19:0] obs;

  int checks = 0;
  int errors = 0;

  multicycle_control_unit #(.OPCODE_W(4), .ALUOP_W(2), .MAX_WAIT(MAX_WAIT)) dut (
    .Clock(Clock), .Reset(Reset), .OPCODE(OPCODE), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .IorD(IorD), .RegDst(RegDst),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .AluSrcB(AluSrcB),
    .AluOp(AluOp), .RegWrite(RegWrite), .Shift(Shift), .InstrDone(InstrDone),
    .Illegal(Illegal), .BusError(BusError), .State(State)
  );

  assign obs = {PCWrite, PCSrc, IRWrite, IorD, RegDst, MemRead, MemWrite, MemToReg,
                AluSrcB, AluOp, RegWrite, Shift, InstrDone, Illegal, BusError, State};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Instruction classes: 0 R, 1 shift, 2 I, 3 LW, 4 SW, 5 BEQ, 6 illegal.
  function automatic int op_class(input logic [3:0] op);
    case (op)
      4'h0, 4'h1:       return 0;
      4'h2:             return 1;
      4'h9, 4'hA, 4'hB: return 2;
      4'hC:             return 3;
      4'hD:             return 4;
      4'hF:             return 5;
      default:          return 6;
    endcase
  endfunction

  function automatic logic [19:0] v(input logic [2:0] st, input logic pcw, pcs, irw, iord,
                                    rd, mr, mw, m2r, input logic [1:0] asb, aop,
                                    input logic rw, sh, dn, il, be);
    return {pcw, pcs, irw, iord, rd, mr, mw, m2r, asb, aop, rw, sh, dn, il, be, st};
  endfunction

  function automatic logic [19:0] fetch_vec(input logic rdy, input logic to);
    return v(3'd0, rdy, 0, rdy, 0, 0, 1, 0, 0, 2'b10, 2'b00, 0, 0, to, 0, to);
  endfunction

  function automatic logic [19:0] decode_vec(input logic ill);
    return v(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, ill, ill, 0);
  endfunction

  function automatic logic [19:0] exec_vec(input int c, input logic z);
    case (c)
      0, 1:    return v(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0, 0);
      2:       return v(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b11, 0, 0, 0, 0, 0);
      3, 4:    return v(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
      default: return v(3'd2, z, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0, 0, 1, 0, 0);
    endcase
  endfunction

  function automatic logic [19:0] mem_vec(input int c, input logic rdy, input logic to);
    logic lw, sw;
    lw = (c == 3);
    sw = (c == 4);
    return v(3'd3, 0, 0, 0, 1, 0, lw, sw, 0, 2'b00, 2'b00, 0, 0, to | (sw & rdy), 0, to);
  endfunction

  function automatic logic [19:0] wb_vec(input int c);
    return v(3'd4, 0, 0, 0, 0, c <= 1, 0, 0, c == 3, 2'b00, 2'b00, 1, c == 1, 1, 0, 0);
  endfunction

  // Model one instruction, then play it. fw/mw are the numbers of not-ready
  // cycles before memory answers in FETCH/MEM.
  task automatic run_instr(input logic [3:0] op, input logic z, input int fw, input int mw,
                           input string name, output int cycles);
    logic        rq[$];
    logic [3:0]  oq[$];
    logic        zq[$];
    logic [19:0] exq[$];
    logic        rdy, to, ended;
    int          c;
    c = op_class(op);
    ended = 1'b0;
    for (int k = 0; k <= MAX_WAIT; k++) begin
      rdy = (k >= fw);
      to  = !rdy && (k == MAX_WAIT);
      rq.push_back(rdy); oq.push_back(4'($urandom)); zq.push_back(1'($urandom));
      exq.push_back(fetch_vec(rdy, to));
      if (to) ended = 1'b1;
      if (to || rdy) break;
    end
    if (!ended) begin
      rq.push_back(1'($urandom)); oq.push_back(op); zq.push_back(1'($urandom));
      exq.push_back(decode_vec(c == 6));
      if (c == 6) ended = 1'b1;
    end
    if (!ended) begin
      rq.push_back(1'($urandom)); oq.push_back(4'($urandom)); zq.push_back(z);
      exq.push_back(exec_vec(c, z));
      if (c == 5) ended = 1'b1;
    end
    if (!ended && (c == 3 || c == 4)) begin
      for (int k = 0; k <= MAX_WAIT; k++) begin
        rdy = (k >= mw);
        to  = !rdy && (k == MAX_WAIT);
        rq.push_back(rdy); oq.push_back(4'($urandom)); zq.push_back(1'($urandom));
        exq.push_back(mem_vec(c, rdy, to));
        if (to || (rdy && c == 4)) ended = 1'b1;
        if (to || rdy) break;
      end
    end
    if (!ended) begin
      rq.push_back(1'($urandom)); oq.push_back(4'($urandom)); zq.push_back(1'($urandom));
      exq.push_back(wb_vec(c));
    end
    for (int i = 0; i < exq.size(); i++) begin
      MemReady = rq[i]; OPCODE = oq[i]; Zero = zq[i];
      @(negedge Clock);
      checks++;
      if (obs !== exq[i]) begin
        errors++;
        $display("FAIL %s op=%h cycle %0d: got %h expected %h", name, op, i, obs, exq[i]);
      end
      @(posedge Clock); #1;
    end
    cycles = exq.size();
  endtask

  task automatic test_reset;
    Reset = 1'b1; OPCODE = 4'h0; Zero = 1'b0; MemReady = 1'b1;
    repeat (2) begin
      @(negedge Clock);
      checks++;
      if (obs !== 20'h0) begin
        errors++;
        $display("FAIL reset_outputs: got %h expected 00000", obs);
      end
    end
    @(posedge Clock); #1;
    Reset = 1'b0;
  endtask

  task automatic test_rtype;
    int n;
    run_instr(4'b0001, 1'b0, 0, 0, "add", n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL add_latency: got %0d expected 4", n); end
    run_instr(4'b0010, 1'b0, 0, 0, "shift", n);
    run_instr(4'b1010, 1'b0, 0, 0, "subi", n);
  endtask

  task automatic test_lw_stall;
    int n;
    run_instr(4'b1100, 1'b0, 0, 0, "lw", n);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL lw_latency: got %0d expected 5", n); end
    run_instr(4'b1100, 1'b0, 0, 3, "lw_stall", n);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL lw_stall_len: got %0d expected 8", n); end
    run_instr(4'b1101, 1'b0, 0, 0, "sw", n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL sw_latency: got %0d expected 4", n); end
  endtask

  task automatic test_beq;
    int n;
    run_instr(4'b1111, 1'b1, 0, 0, "beq_taken", n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL beq_taken_len: got %0d expected 3", n); end
    run_instr(4'b1111, 1'b0, 0, 0, "beq_not_taken", n);
    checks++;
    if (n !== 3) begin errors++; $display("FAIL beq_nt_len: got %0d expected 3", n); end
  endtask

  task automatic test_illegal;
    int n;
    run_instr(4'b0101, 1'b0, 0, 0, "illegal", n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL illegal_len: got %0d expected 2", n); end
  endtask

  task automatic test_timeouts;
    int n;
    run_instr(4'b0001, 1'b0, 100, 0, "fetch_timeout", n);
    checks++;
    if (n !== MAX_WAIT + 1) begin
      errors++; $display("FAIL fetch_timeout_len: got %0d expected %0d", n, MAX_WAIT + 1);
    end
    // Ready on the last allowed cycle wins over the timeout; this also
    // relies on the counter having restarted after the bus error.
    run_instr(4'b1101, 1'b0, MAX_WAIT, MAX_WAIT, "ready_priority", n);
    checks++;
    if (n !== 2 * MAX_WAIT + 4) begin
      errors++; $display("FAIL priority_len: got %0d expected %0d", n, 2 * MAX_WAIT + 4);
    end
    run_instr(4'b1100, 1'b0, 1, 100, "mem_timeout", n);
    checks++;
    if (n !== MAX_WAIT + 5) begin
      errors++; $display("FAIL mem_timeout_len: got %0d expected %0d", n, MAX_WAIT + 5);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    MemReady = 1'b1; OPCODE = 4'h7;
    @(negedge Clock);
    @(posedge Clock); #1;
    OPCODE = 4'b0001;
    @(posedge Clock); #1;
    OPCODE = 4'h6;
    @(negedge Clock);
    checks++;
    if (State !== 3'd2) begin errors++; $display("FAIL mid_exec_state: got %0d expected 2", State); end
    Reset = 1'b1;
    #1;
    checks++;
    if (obs !== 20'h0) begin errors++; $display("FAIL async_reset: got %h expected 00000", obs); end
    repeat (3) begin
      @(posedge Clock); @(negedge Clock);
      checks++;
      if (obs !== 20'h0) begin errors++; $display("FAIL reset_hold: got %h expected 00000", obs); end
    end
    @(posedge Clock); #1;
    Reset = 1'b0;
    run_instr(4'b0001, 1'b0, 0, 0, "after_reset", n);
  endtask

  task automatic test_random;
    int n, r, fw, mw;
    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 9);
      fw = (r < 7) ? $urandom_range(0, 2) : $urandom_range(MAX_WAIT - 2, MAX_WAIT + 3);
      r  = $urandom_range(0, 9);
      mw = (r < 7) ? $urandom_range(0, 3) : $urandom_range(MAX_WAIT - 2, MAX_WAIT + 3);
      run_instr(4'($urandom), 1'($urandom), fw, mw, "random", n);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_beq();
    test_illegal();
    test_timeouts();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle opcode decoder in the 16-bit CPU.
- Registered FSM sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives datapath/memory control per state, stalls on a memory-ready handshake, times out hung accesses, and flags illegal opcodes.
- Sits between the instruction register (OPCODE source) and the shared-memory datapath.

Parameters:
- OPCODE_W, 4, opcode width. Values with any bit above bit 3 set are illegal.
- ALUOP_W, 2, AluOp width. Encodings 00/01/10/11 occupy the low two bits; upper bits are driven 0.
- MAX_WAIT, 15, memory wait-cycle limit before a bus error (1..255).

Ports:
- Clock      in   1         rising-edge clock
- Reset      in   1         asynchronous, active-high
- OPCODE     in   OPCODE_W  instruction opcode from the instruction register, valid from DECODE onward
- Zero       in   1         ALU zero flag
- MemReady   in   1         memory completes the access this cycle
- PCWrite    out  1         load PC
- PCSrc      out  1         0 = PC+2, 1 = branch target
- IRWrite    out  1         load instruction register
- IorD       out  1         memory address select: 0 = PC, 1 = ALU result
- RegDst     out  1         1 = rd, 0 = rt
- MemRead    out  1         memory read request
- MemWrite   out  1         memory write request
- MemToReg   out  1         writeback select: memory data
- AluSrcB    out  2         00 = reg, 01 = imm, 10 = 2, 11 = imm<<1
- AluOp      out  ALUOP_W   00 = add, 01 = sub/compare, 10 = funct, 11 = imm-op
- RegWrite   out  1         register file write
- Shift      out  1         shifter path select
- InstrDone  out  1         1-cycle pulse in the final cycle of each instruction
- Illegal    out  1         1-cycle pulse on an undefined opcode
- BusError   out  1         1-cycle pulse on memory timeout
- State      out  3         0 = FETCH, 1 = DECODE, 2 = EXEC, 3 = MEM, 4 = WB

Behaviour:
- Reset asserted: State = FETCH, wait counter = 0, op_q = 0, every output 0, including while Reset is high. Reset mid-instruction aborts it with no write or pulse.
- All outputs decode combinationally from registered State, op_q and the counter. No OPCODE-to-output combinational path except in DECODE.
- op_q latches OPCODE on the clock edge leaving DECODE.
- Opcode classes:
  - 0000 logic, 0001 add/sub: R-type.
  - 0010 shift: R-type with Shift = 1.
  - 1001 ADDI, 1010 SUBI, 1011 SLTI: I-type.
  - 1100 LW, 1101 SW, 1111 BEQ.
  - All others illegal.
- FETCH:
  - MemRead = 1, IorD = 0, AluSrcB = 10, AluOp = 00.
  - While MemReady = 0: stay, counter increments.
  - MemReady = 1: IRWrite = 1, PCWrite = 1, PCSrc = 0, go to DECODE.
- DECODE:
  - AluSrcB = 11, AluOp = 00 (branch target precompute).
  - Illegal OPCODE: Illegal = 1, InstrDone = 1, go to FETCH.
  - Otherwise go to EXEC.
- EXEC:
  - R-type: AluSrcB = 00, AluOp = 10.
  - I-type: AluSrcB = 01, AluOp = 11.
  - LW/SW: AluSrcB = 01, AluOp = 00.
  - BEQ: AluSrcB = 00, AluOp = 01, PCSrc = 1, PCWrite = Zero, InstrDone = 1, go to FETCH.
  - LW/SW go to MEM; everything else goes to WB.
- MEM:
  - IorD = 1. LW: MemRead = 1. SW: MemWrite = 1.
  - Stall while MemReady = 0.
  - LW with MemReady = 1: go to WB.
  - SW with MemReady = 1: InstrDone = 1, go to FETCH.
- WB:
  - RegWrite = 1, InstrDone = 1, go to FETCH.
  - RegDst = 1 for R-type, 0 otherwise. MemToReg = 1 for LW only. Shift = 1 for 0010.
- Wait counter:
  - Cleared on any state change.
  - In FETCH/MEM with MemReady = 0 and counter == MAX_WAIT: BusError = 1, InstrDone = 1, no IRWrite/PCWrite/RegWrite, go to FETCH.
  - MemReady = 1 in that same cycle takes priority over the timeout.
- Latency with MemReady = 1 throughout: BEQ 3 cycles, R/I-type 4, SW 4, LW 5.

Test Plan:
- Reset held 3 cycles mid-EXEC of ADD, then released → State = 0 and all outputs 0 during reset; fetch restarts with no RegWrite pulse.
- MemReady = 1 constantly, OPCODE = 0001 → States 0,1,2,4; WB has RegWrite = 1, RegDst = 1; InstrDone on cycle 4.
- OPCODE = 1100, MemReady low 3 cycles in MEM → MEM held 4 cycles with MemRead = 1, IorD = 1; then WB with MemToReg = 1, RegDst = 0.
- OPCODE = 1111 with Zero = 1, then Zero = 0 → EXEC PCWrite = 1 then 0, PCSrc = 1; 3-cycle instruction both times.
- OPCODE = 0101 → Illegal and InstrDone pulse in DECODE; next state FETCH; no RegWrite/MemWrite.
- MAX_WAIT = 15, MemReady stuck 0 in FETCH → BusError pulses on the 16th FETCH cycle, IRWrite never set; state returns to FETCH with counter 0.
